uart_rx_deframer: RTL

//  Serial receiver for the SoC UART transmit line (externalPins_uart_tx): 8N1 deframing into bytes.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_byte_fifo.sv | 49 ++++
 rtl/uart_rx_deframer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and default timing constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 434;
  localparam int unsigned UART_FIFO_DEPTH   = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a pop frees a slot for a same-cycle push.
module uart_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads as zero until the first write.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: line synchroniser, mid-bit sampling FSM, byte FIFO with valid/ready,
// and single-cycle framing-error / overrun pulses.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       out_valid,
  input  logic       out_ready,
  output uart_byte_t out_data,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW    = $clog2(UART_DATA_BITS);
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  // START is entered one cycle after the edge is seen, so its count lags by one.
  localparam logic [CW-1:0] START_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST   = BW'(UART_DATA_BITS - 1);

  logic        rx_meta;
  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  uart_byte_t  shift_q, shift_d;
  logic        push_c;
  logic        ferr_c;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop_c;
  logic        ovr_c;

  assign out_valid = !fifo_empty;
  assign pop_c     = out_valid && out_ready;
  assign ovr_c     = push_c && fifo_full && !pop_c;

  // Next-state, sampling and byte-completion decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    push_c  = 1'b0;
    ferr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            push_c  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_c  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchroniser, FSM state and registered status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      frame_err <= ferr_c;
      overrun   <= ovr_c;
      busy      <= (state_d != IDLE);
    end
  end

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (shift_q),
    .full      (fifo_full),
    .pop       (pop_c),
    .empty     (fifo_empty),
    .head_data (out_data)
  );

endmodule
